// File: rtl/note_player.sv
// note_player: plays a song from the note library, one beat per note, as a square-wave buzzer tone.
// Optional feature NOTE_PLAYER_LOOP_EN: restart the song from index 0 instead of stopping.
module note_player #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_song_select,
  input  logic              i_start,
  input  logic              i_pause,
  output logic [1:0]        o_lib_select,
  output logic [ADDR_W-1:0] o_note_index,
  input  logic [3:0]        i_note,
  input  logic              i_end_of_song,
  output logic              o_buzzer,
  output logic              o_playing,
  output logic [3:0]        o_cur_note,
  output logic              o_done
);

  localparam int unsigned HalfC4 = CLK_HZ / (2 * 262);
  localparam int unsigned HalfD4 = CLK_HZ / (2 * 294);
  localparam int unsigned HalfE4 = CLK_HZ / (2 * 330);
  localparam int unsigned HalfF4 = CLK_HZ / (2 * 349);
  localparam int unsigned HalfG4 = CLK_HZ / (2 * 392);
  localparam int unsigned HalfA4 = CLK_HZ / (2 * 440);
  localparam int unsigned HalfB4 = CLK_HZ / (2 * 494);
  localparam int unsigned HalfC5 = CLK_HZ / (4 * 262);
  localparam int unsigned HalfD5 = CLK_HZ / (4 * 294);
  localparam int unsigned HalfE5 = CLK_HZ / (4 * 330);
  localparam int unsigned HalfF5 = CLK_HZ / (4 * 349);
  localparam int unsigned HalfG5 = CLK_HZ / (4 * 392);
  localparam int unsigned HalfA5 = CLK_HZ / (4 * 440);
  localparam int unsigned HalfB5 = CLK_HZ / (4 * 494);

  localparam int unsigned BeatW = $clog2(BEAT_CYCLES);
  localparam int unsigned ToneW = $clog2(HalfC4);

  localparam logic [BeatW-1:0]  PlayLast = BeatW'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [BeatW-1:0]  BeatLast = BeatW'(BEAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IdxLast  = '1;

  typedef enum logic [2:0] {StIdle, StFetch, StPlay, StGap, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [1:0]         r_lib_select, w_lib_select_d;
  logic [ADDR_W-1:0]  r_note_index, w_note_index_d;
  logic [3:0]         r_cur_note, w_cur_note_d;
  logic [BeatW-1:0]   r_beat_cnt, w_beat_cnt_d;
  logic [ToneW-1:0]   r_tone_cnt, w_tone_cnt_d;
  logic               r_buzzer, w_buzzer_d;
  logic [ToneW-1:0]   w_half_m1;

  always_comb begin
    w_half_m1 = ToneW'(HalfC4 - 1);
    case (r_cur_note)
      4'd1:    w_half_m1 = ToneW'(HalfC4 - 1);
      4'd2:    w_half_m1 = ToneW'(HalfD4 - 1);
      4'd3:    w_half_m1 = ToneW'(HalfE4 - 1);
      4'd4:    w_half_m1 = ToneW'(HalfF4 - 1);
      4'd5:    w_half_m1 = ToneW'(HalfG4 - 1);
      4'd6:    w_half_m1 = ToneW'(HalfA4 - 1);
      4'd7:    w_half_m1 = ToneW'(HalfB4 - 1);
      4'd8:    w_half_m1 = ToneW'(HalfC5 - 1);
      4'd9:    w_half_m1 = ToneW'(HalfD5 - 1);
      4'd10:   w_half_m1 = ToneW'(HalfE5 - 1);
      4'd11:   w_half_m1 = ToneW'(HalfF5 - 1);
      4'd12:   w_half_m1 = ToneW'(HalfG5 - 1);
      4'd13:   w_half_m1 = ToneW'(HalfA5 - 1);
      4'd14:   w_half_m1 = ToneW'(HalfB5 - 1);
      default: w_half_m1 = ToneW'(HalfC4 - 1);
    endcase
  end

  always_comb begin
    w_state_d      = r_state;
    w_lib_select_d = r_lib_select;
    w_note_index_d = r_note_index;
    w_cur_note_d   = r_cur_note;
    w_beat_cnt_d   = r_beat_cnt;
    w_tone_cnt_d   = r_tone_cnt;
    w_buzzer_d     = r_buzzer;
    // start wins over pause and over the end-of-beat advance
    if (i_start) begin
      w_state_d      = StFetch;
      w_lib_select_d = i_song_select;
      w_note_index_d = '0;
      w_cur_note_d   = '0;
      w_buzzer_d     = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_buzzer_d = 1'b0;
        end
        StFetch: begin
          w_buzzer_d = 1'b0;
          if (i_end_of_song || (i_note == 4'hF)) begin
            w_state_d    = StDone;
            w_cur_note_d = '0;
          end else begin
            w_state_d    = StPlay;
            w_cur_note_d = i_note;
            w_beat_cnt_d = '0;
            w_tone_cnt_d = '0;
          end
        end
        StPlay: begin
          if (!i_pause) begin
            w_beat_cnt_d = r_beat_cnt + 1'b1;
            if (r_cur_note != 4'd0) begin
              if (r_tone_cnt == w_half_m1) begin
                w_tone_cnt_d = '0;
                w_buzzer_d   = ~r_buzzer;
              end else begin
                w_tone_cnt_d = r_tone_cnt + 1'b1;
              end
            end
            if (r_beat_cnt == PlayLast) begin
              w_state_d  = StGap;
              w_buzzer_d = 1'b0;
            end
          end
        end
        StGap: begin
          w_buzzer_d = 1'b0;
          if (!i_pause) begin
            w_beat_cnt_d = r_beat_cnt + 1'b1;
            if (r_beat_cnt == BeatLast) begin
              if (r_note_index == IdxLast) begin
                w_state_d    = StDone;
                w_cur_note_d = '0;
              end else begin
                w_state_d      = StFetch;
                w_note_index_d = r_note_index + 1'b1;
              end
            end
          end
        end
        StDone: begin
          w_buzzer_d     = 1'b0;
          w_note_index_d = '0;
`ifdef NOTE_PLAYER_LOOP_EN
          w_state_d      = StFetch;
`else
          w_state_d      = StIdle;
`endif
        end
        default: begin
          w_state_d  = StIdle;
          w_buzzer_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_lib_select <= '0;
      r_note_index <= '0;
      r_cur_note   <= '0;
      r_beat_cnt   <= '0;
      r_tone_cnt   <= '0;
      r_buzzer     <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_lib_select <= w_lib_select_d;
      r_note_index <= w_note_index_d;
      r_cur_note   <= w_cur_note_d;
      r_beat_cnt   <= w_beat_cnt_d;
      r_tone_cnt   <= w_tone_cnt_d;
      r_buzzer     <= w_buzzer_d;
    end
  end

  // Pause mutes combinationally; the tone phase itself is held in r_buzzer.
  always_comb begin
    o_lib_select = r_lib_select;
    o_note_index = r_note_index;
    o_cur_note   = r_cur_note;
    o_buzzer     = r_buzzer && (r_state == StPlay) && !i_pause;
    o_done       = (r_state == StDone);
`ifdef NOTE_PLAYER_LOOP_EN
    o_playing    = (r_state == StFetch) || (r_state == StPlay) || (r_state == StGap) ||
                   (r_state == StDone);
`else
    o_playing    = (r_state == StFetch) || (r_state == StPlay) || (r_state == StGap);
`endif
  end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: beat-level reference model checked every cycle plus literal timing pins.
module tb_note_player;
  localparam int unsigned ClkHz = 100_000;
  localparam int unsigned Beat  = 400;
  localparam int unsigned Gap   = 40;
  localparam int unsigned AddrW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       song_select = '0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic [1:0]       lib_select;
  logic [AddrW-1:0] note_index;
  logic [3:0]       note;
  logic             end_of_song;
  logic             buzzer, playing, done;
  logic [3:0]       cur_note;

  always #5 clk = ~clk;

  note_player #(.CLK_HZ(ClkHz), .BEAT_CYCLES(Beat), .GAP_CYCLES(Gap), .ADDR_W(AddrW)) dut (
    .i_clk(clk), .i_rst(rst), .i_song_select(song_select), .i_start(start), .i_pause(pause),
    .o_lib_select(lib_select), .o_note_index(note_index), .i_note(note),
    .i_end_of_song(end_of_song), .o_buzzer(buzzer), .o_playing(playing),
    .o_cur_note(cur_note), .o_done(done)
  );

  // Library: {end_of_song, note}
  logic [4:0] lib [4][16];
  assign note        = lib[lib_select][note_index][3:0];
  assign end_of_song = lib[lib_select][note_index][4];

  int n_vec = 0;
  int n_err = 0;
  int t_now = 0;

  // ---------------- reference model ----------------
  typedef enum {MIdle, MFetch, MSound, MDone} mst_t;
  mst_t m_st = MIdle;
  int   m_idx = 0, m_sel = 0, m_note = 0, m_e = 0;
  bit   m_valid = 1'b0;

  function automatic int half_of(input int n);
    int base, f;
    base = (n > 7) ? n - 7 : n;
    case (base)
      1: f = 262; 2: f = 294; 3: f = 330; 4: f = 349;
      5: f = 392; 6: f = 440; 7: f = 494;
      default: f = 262;
    endcase
    return ClkHz / (2 * f * ((n > 7) ? 2 : 1));
  endfunction

  initial forever begin
    int n;
    bit eos;
    @(posedge clk);
    if (rst) begin
      m_st = MIdle; m_idx = 0; m_sel = 0; m_note = 0; m_e = 0; m_valid = 1'b1;
    end else if (start) begin
      m_sel = song_select; m_idx = 0; m_note = 0; m_st = MFetch;
    end else begin
      case (m_st)
        MFetch: begin
          n   = lib[m_sel][m_idx][3:0];
          eos = lib[m_sel][m_idx][4];
          if (eos || n == 15) begin m_st = MDone; m_note = 0; end
          else begin m_note = n; m_e = 0; m_st = MSound; end
        end
        MSound: if (!pause) begin
          if (m_e == Beat - 1) begin
            if (m_idx == 15) begin m_st = MDone; m_note = 0; end
            else begin m_idx++; m_st = MFetch; end
          end else m_e++;
        end
        MDone: begin
          m_idx = 0;
`ifdef NOTE_PLAYER_LOOP_EN
          m_st = MFetch;
`else
          m_st = MIdle;
`endif
        end
        default: ;
      endcase
    end
  end

  initial forever begin
    int e_buz, e_ply, e_done;
    @(negedge clk);
    if (m_valid) begin
      e_buz = (m_st == MSound && !pause && m_e < Beat - Gap && m_note != 0 &&
               ((m_e / half_of(m_note)) % 2 == 1)) ? 1 : 0;
`ifdef NOTE_PLAYER_LOOP_EN
      e_ply = (m_st != MIdle) ? 1 : 0;
`else
      e_ply = (m_st == MFetch || m_st == MSound) ? 1 : 0;
`endif
      e_done = (m_st == MDone) ? 1 : 0;
      n_vec++;
      if (buzzer !== e_buz[0] || playing !== e_ply[0] || done !== e_done[0] ||
          note_index !== m_idx[AddrW-1:0] || lib_select !== m_sel[1:0] ||
          cur_note !== m_note[3:0]) begin
        n_err++;
        if (n_err <= 20)
          $display("FAIL cycle_model @%0t: dut buz=%0d ply=%0d done=%0d idx=%0d sel=%0d cur=%0d, required buz=%0d ply=%0d done=%0d idx=%0d sel=%0d cur=%0d",
                   $time, buzzer, playing, done, note_index, lib_select, cur_note,
                   e_buz, e_ply, e_done, m_idx, m_sel, m_note);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; t_now++; end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic start_song(input int sel);
    song_select = sel[1:0];
    start = 1'b1;
    step(1);
    start = 1'b0;
    t_now = 1;
  endtask

  function automatic int sig(input int which);
    case (which)
      0: return int'(buzzer);
      1: return int'(done);
      2: return int'(note_index);
      default: return int'(playing);
    endcase
  endfunction

  // Returns the song-relative cycle where the signal first equals val, or -1 on timeout.
  task automatic wait_for(input int which, input int val, input int max, output int t);
    t = -1;
    for (int k = 0; k < max; k++) begin
      if (sig(which) == val) begin t = t_now; break; end
      step(1);
    end
  endtask

  int t;
  int idle_play;

  initial begin
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 16; i++) lib[s][i] = 5'h0F;
    for (int i = 0; i < 16; i++) lib[0][i] = (i == 15) ? 5'd7 : 5'(i);
    lib[1][0] = 5'd6;  lib[1][1] = 5'd0;  lib[1][2] = 5'd15;
    lib[2][0] = 5'd3;  lib[2][1] = 5'd5;  lib[2][2] = 5'd15;
    lib[3][0] = 5'd1;  lib[3][1] = 5'd8;  lib[3][2] = 5'd14; lib[3][3] = 5'h12;
`ifdef NOTE_PLAYER_LOOP_EN
    idle_play = 1;
`else
    idle_play = 0;
`endif

    step(2);
    rst = 1'b0;
    check("reset_playing", playing, 0);
    check("reset_buzzer", buzzer, 0);
    check("reset_index", note_index, 0);
    check("reset_select", lib_select, 0);
    check("reset_done", done, 0);
    check("reset_cur_note", cur_note, 0);

    // Reset mid-PLAY aborts at once
    start_song(1);
    step(49);
    check("pre_reset_playing", playing, 1);
    rst = 1'b1;
    step(1);
    check("midreset_playing", playing, 0);
    check("midreset_buzzer", buzzer, 0);
    check("midreset_index", note_index, 0);
    rst = 1'b0;
    step(2);

    // Song {A4, rest, end}: A4 half-period is 113 clocks
    start_song(1);
    wait_for(0, 1, 300, t);
    check("a4_first_rise", t, 115);
    check("a4_cur_note", cur_note, 6);
    wait_for(0, 0, 300, t);
    check("a4_first_fall", t, 228);
    wait_for(2, 1, 1000, t);
    check("song1_index1", t, 402);
    wait_for(1, 1, 1000, t);
    check("song1_done_time", t, 804);
    check("song1_done_cur_note", cur_note, 0);
    step(1);
    check("song1_done_width", done, 0);
    check("song1_after_playing", playing, idle_play);
    step(3);

    // All 16 notes non-end; song_select change mid-song is ignored
    start_song(0);
    wait_for(2, 3, 2000, t);
    check("song0_index3", t, 1204);
    song_select = 2'd2;
    wait_for(1, 1, 8000, t);
    check("song0_done_time", t, 6417);
    check("song0_done_index", note_index, 15);
    check("song0_select_kept", lib_select, 0);
    step(3);

    // Pause 100 cycles mid-PLAY stretches the beat to 500
    start_song(2);
    step(49);
    pause = 1'b1;
    step(50);
    check("pause_buzzer", buzzer, 0);
    check("pause_index", note_index, 0);
    check("pause_playing", playing, 1);
    step(50);
    pause = 1'b0;
    wait_for(2, 1, 1000, t);
    check("pause_beat_len", t, 502);
    step(150);
    pause = 1'b1;
    start_song(1);
    pause = 1'b0;
    check("start_over_pause_sel", lib_select, 1);
    check("start_over_pause_idx", note_index, 0);
    wait_for(1, 1, 1000, t);
    check("restart_done_time", t, 804);
    step(3);

    // Restart at index 5 with a new song_select
    start_song(0);
    wait_for(2, 5, 3000, t);
    check("song0_index5", t, 2006);
    step(10);
    start_song(1);
    check("restart_select", lib_select, 1);
    check("restart_index", note_index, 0);
    check("restart_playing", playing, 1);
    wait_for(1, 1, 1000, t);
    check("restart_song1_done", t, 804);
    step(3);

    // end_of_song flag with a non-15 note, octave notes
    start_song(3);
    wait_for(0, 1, 300, t);
    check("c4_first_rise", t, 192);
    wait_for(1, 1, 2000, t);
    check("eos_done_time", t, 1205);
    step(3);

`ifdef NOTE_PLAYER_LOOP_EN
    start_song(2);
    wait_for(1, 1, 1000, t);
    check("loop_done_time", t, 804);
    step(1);
    check("loop_index", note_index, 0);
    check("loop_playing", playing, 1);
    step(5);
`endif

    rst = 1'b1;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
